// File: rtl/cosim_run_ctrl_if.sv
// Bundle of configuration, handshake and status signals for cosim_run_ctrl.
//   master : cosim testbench side, drives config and handshake, observes status
//   slave  : cosim_run_ctrl, consumes config and handshake, drives status
// Signals:
//   cfg_timeout      max cycles without commit_valid in RUN (0 = no watchdog)
//   cfg_quit_timeout max cycles in DRAIN waiting for idle
//   commit_valid     one instruction committed this cycle
//   quit_req         cosim model requests quit
//   idle             testbench datapath idle
//   dut_reset        active-high reset to the DUT
//   init_flag        DUT init window indicator
//   cycle            cycles elapsed since reset release
//   state            INIT=0 RUN=1 DRAIN=2 PASS=3 FAIL=4
//   done/pass        run finished / finished successfully
//   fail_code        0 none, 1 watchdog, 2 idle timeout after quit, 3 quit in INIT
interface cosim_run_ctrl_if;
  logic [31:0] cfg_timeout;
  logic [31:0] cfg_quit_timeout;
  logic        commit_valid;
  logic        quit_req;
  logic        idle;
  logic        dut_reset;
  logic        init_flag;
  logic [63:0] cycle;
  logic [2:0]  state;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;

  modport master (
    output cfg_timeout, cfg_quit_timeout, commit_valid, quit_req, idle,
    input  dut_reset, init_flag, cycle, state, done, pass, fail_code
  );

  modport slave (
    input  cfg_timeout, cfg_quit_timeout, commit_valid, quit_req, idle,
    output dut_reset, init_flag, cycle, state, done, pass, fail_code
  );
endinterface

// File: rtl/cosim_run_ctrl.sv
// Co-simulation run controller. Sequences DUT reset/init, watches commit
// progress with a watchdog, handles quit with an idle drain window and
// reports a terminal PASS/FAIL status.
// Ports:
//   clock  sole clock, rising edge
//   reset  synchronous active-low reset
//   bus    cosim_run_ctrl_if.slave (config, handshake and status)
// Parameters:
//   RESET_CYCLES  cycles dut_reset is held after reset release (1..255)
//   INIT_CYCLES   cycles init_flag is held after reset release (0..RESET_CYCLES)
module cosim_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned INIT_CYCLES  = 1
) (
  input  logic              clock,
  input  logic              reset,
  cosim_run_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  localparam logic [7:0] INIT_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] INIT_LEN  = 8'(INIT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  init_cnt_q, init_cnt_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] drain_q, drain_d;
  logic [31:0] to_q, to_d;
  logic [31:0] qto_q, qto_d;
  logic [1:0]  code_q, code_d;
  logic [63:0] cycle_q;
  logic        dut_reset_q, dut_reset_d;
  logic        init_flag_q, init_flag_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wd_d       = wd_q;
    drain_d    = drain_q;
    to_d       = to_q;
    qto_d      = qto_q;
    code_d     = code_q;

    unique case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + 8'd1;
        if (bus.quit_req) begin
          state_d = S_FAIL;
          code_d  = 2'd3;
        end else if (init_cnt_q == INIT_LAST) begin
          state_d = S_RUN;
          to_d    = bus.cfg_timeout;
          qto_d   = bus.cfg_quit_timeout;
          wd_d    = '0;
        end
      end

      S_RUN: begin
        // quit outranks commit, commit outranks watchdog expiry
        if (bus.quit_req) begin
          if (bus.idle) begin
            state_d = S_PASS;
          end else begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end else if (bus.commit_valid) begin
          wd_d = '0;
        end else if ((to_q != '0) && (wd_q == to_q)) begin
          state_d = S_FAIL;
          code_d  = 2'd1;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 32'd1;
        end
      end

      S_DRAIN: begin
        // idle wins over an expiring drain window; a zero window fails at once
        if (bus.idle) begin
          state_d = S_PASS;
        end else if (drain_q == qto_q) begin
          state_d = S_FAIL;
          code_d  = 2'd2;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end

      S_PASS, S_FAIL: begin
        state_d = state_q;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    // Status flops are loaded from next-state values so every decision shows
    // up on the outputs exactly one cycle after its inputs were sampled.
    dut_reset_d = (state_d == S_INIT);
    init_flag_d = (state_d == S_INIT) && (init_cnt_d < INIT_LEN);
    done_d      = (state_d == S_PASS) || (state_d == S_FAIL);
    pass_d      = (state_d == S_PASS);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      wd_q        <= '0;
      drain_q     <= '0;
      to_q        <= '0;
      qto_q       <= '0;
      code_q      <= '0;
      cycle_q     <= '0;
      dut_reset_q <= 1'b1;
      init_flag_q <= (INIT_CYCLES > 0);
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      wd_q        <= wd_d;
      drain_q     <= drain_d;
      to_q        <= to_d;
      qto_q       <= qto_d;
      code_q      <= code_d;
      dut_reset_q <= dut_reset_d;
      init_flag_q <= init_flag_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      if (cycle_q != '1) begin
        cycle_q <= cycle_q + 64'd1;
      end
    end
  end

  assign bus.dut_reset = dut_reset_q;
  assign bus.init_flag = init_flag_q;
  assign bus.cycle     = cycle_q;
  assign bus.state     = state_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_code = code_q;

endmodule

// File: tb/tb_cosim_run_ctrl.sv
// Self-checking bench for cosim_run_ctrl: directed scenarios plus randomized
// runs, all compared against a cycle-count based reference model.
module tb_cosim_run_ctrl;

  localparam int unsigned RC = 5;
  localparam int unsigned IC = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cosim_run_ctrl_if bus ();

  cosim_run_ctrl #(
    .RESET_CYCLES (RC),
    .INIT_CYCLES  (IC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0..4 (INIT..FAIL), elapsed cycle count and the
  // cycle numbers at which the watchdog / drain windows (re)started.
  int              m_phase = 0;
  int              m_code  = 0;
  longint unsigned m_cyc   = 0;
  longint unsigned m_last  = 0;
  longint unsigned m_dstart = 0;
  longint unsigned m_to    = 0;
  longint unsigned m_qto   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h time=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    longint unsigned t;
    longint unsigned wd;
    longint unsigned d;
    if (!reset) begin
      m_phase = 0;
      m_code  = 0;
      m_cyc   = 0;
    end else begin
      t = m_cyc;
      case (m_phase)
        0: begin
          // init counter equals cycles since release
          if (bus.quit_req) begin
            m_phase = 4; m_code = 3;
          end else if (t == longint'(RC - 1)) begin
            m_phase = 1;
            m_to    = bus.cfg_timeout;
            m_qto   = bus.cfg_quit_timeout;
            m_last  = t + 1;
          end
        end
        1: begin
          wd = t - m_last;
          if (wd > 64'hFFFF_FFFF) wd = 64'hFFFF_FFFF;
          if (bus.quit_req) begin
            if (bus.idle) m_phase = 3;
            else begin
              m_phase  = 2;
              m_dstart = t + 1;
            end
          end else if (bus.commit_valid) begin
            m_last = t + 1;
          end else if (m_to != 0 && wd == m_to) begin
            m_phase = 4; m_code = 1;
          end
        end
        2: begin
          d = t - m_dstart;
          if (bus.idle) m_phase = 3;
          else if (d == m_qto) begin
            m_phase = 4; m_code = 2;
          end
        end
        default: ;
      endcase
      if (m_cyc != 64'hFFFF_FFFF_FFFF_FFFF) m_cyc++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_eq("state", 64'(bus.state), 64'(m_phase));
    check_eq("cycle", bus.cycle, m_cyc);
    check_eq("done", 64'(bus.done), 64'(m_phase >= 3));
    check_eq("pass", 64'(bus.pass), 64'(m_phase == 3));
    check_eq("fail_code", 64'(bus.fail_code), 64'(m_code));
    if (m_phase <= 2) begin
      check_eq("dut_reset", 64'(bus.dut_reset), 64'(m_phase == 0));
      check_eq("init_flag", 64'(bus.init_flag), 64'(m_phase == 0 && m_cyc < IC));
    end
  endtask

  task automatic set_in(input logic c, input logic q, input logic i);
    bus.commit_valid = c;
    bus.quit_req     = q;
    bus.idle         = i;
  endtask

  task automatic do_reset(input logic [31:0] to, input logic [31:0] qto);
    bus.cfg_timeout      = to;
    bus.cfg_quit_timeout = qto;
    set_in(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Ticks until state==s or the budget expires; returns ticks taken.
  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (bus.state !== s && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    bus.cfg_timeout      = '0;
    bus.cfg_quit_timeout = '0;
    set_in(1'b0, 1'b0, 1'b0);

    // Reset sequencing and watchdog expiry; config changed after RUN entry
    do_reset(32'd10, 32'd4);
    wait_state(3'd1, 20, n);
    check_eq("run_entry", 64'(n), 64'd5);
    bus.cfg_timeout = 32'd3;
    wait_state(3'd4, 30, n);
    check_eq("wd_latency", 64'(n), 64'd11);
    check_eq("wd_code", 64'(bus.fail_code), 64'd1);

    // Commits every 5 cycles keep a 10-cycle watchdog happy
    do_reset(32'd10, 32'd4);
    wait_state(3'd1, 20, n);
    for (int i = 0; i < 60; i++) begin
      set_in((i % 5) == 4, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0);
    check_eq("commit_keepalive", 64'(bus.state), 64'd1);

    // Quit while idle -> PASS next cycle
    do_reset(32'd0, 32'd4);
    wait_state(3'd1, 20, n);
    set_in(1'b0, 1'b1, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    check_eq("quit_idle_pass", 64'(bus.pass), 64'd1);

    // Quit with never-idle datapath -> drain timeout
    do_reset(32'd0, 32'd4);
    wait_state(3'd1, 20, n);
    set_in(1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 1'b0);  // commit/quit ignored in DRAIN
    wait_state(3'd4, 20, n);
    set_in(1'b0, 1'b0, 1'b0);
    check_eq("drain_latency", 64'(n), 64'd5);
    check_eq("drain_code", 64'(bus.fail_code), 64'd2);

    // Idle arriving on the last drain cycle wins
    do_reset(32'd0, 32'd4);
    wait_state(3'd1, 20, n);
    set_in(1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    set_in(1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    check_eq("drain_idle_last", 64'(bus.state), 64'd3);

    // Quit and watchdog expiry in the same cycle
    for (int v = 0; v < 2; v++) begin
      do_reset(32'd3, 32'd2);
      wait_state(3'd1, 20, n);
      for (int i = 0; i < 3; i++) tick();
      set_in(1'b0, 1'b1, v == 0);
      tick();
      set_in(1'b0, 1'b0, 1'b0);
      check_eq("quit_beats_wd", 64'(bus.state), (v == 0) ? 64'd3 : 64'd2);
      for (int i = 0; i < 4; i++) tick();
    end

    // Zero drain window fails on first non-idle DRAIN cycle
    do_reset(32'd0, 32'd0);
    wait_state(3'd1, 20, n);
    set_in(1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    tick();
    check_eq("qto_zero", 64'(bus.fail_code), 64'd2);

    // Quit during INIT
    do_reset(32'd0, 32'd4);
    tick();
    set_in(1'b0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b0);
    check_eq("quit_init", 64'(bus.fail_code), 64'd3);
    tick();

    // One-cycle reset pulse out of FAIL
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("rst_state", 64'(bus.state), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_cycle", bus.cycle, 64'd0);
    tick();
    check_eq("rst_cycle_next", bus.cycle, 64'd1);

    // Randomized runs against the model
    for (int r = 0; r < 40; r++) begin
      do_reset($urandom_range(0, 12), $urandom_range(0, 6));
      for (int i = 0; i < 70; i++) begin
        set_in($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
               $urandom_range(0, 2) == 0);
        if ($urandom_range(0, 9) == 0) bus.cfg_timeout = $urandom_range(0, 12);
        if ($urandom_range(0, 9) == 0) bus.cfg_quit_timeout = $urandom_range(0, 6);
        reset = ($urandom_range(0, 99) != 0);
        tick();
      end
      reset = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cosim_run_ctrl.md
COSIM_RUN_CTRL -- requirements
Module: cosim_run_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 5, meaning number of cycles dut_reset is held after reset release (legal range 1..255).
REQ-002 SHALL have parameter INIT_CYCLES, default 1, meaning number of cycles init_flag is held after reset release (legal range 0..RESET_CYCLES).
REQ-003 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cfg_timeout  input  32  max cycles without commit_valid in RUN; 0 disables the watchdog.
REQ-006 SHALL have port cfg_quit_timeout  input  32  max cycles in DRAIN waiting for idle.
REQ-007 SHALL have port commit_valid  input  1  one instruction committed this cycle.
REQ-008 SHALL have port quit_req  input  1  cosim model requests quit.
REQ-009 SHALL have port idle  input  1  testbench datapath idle.
REQ-010 SHALL have port dut_reset  output  1  active-high reset to DUT.
REQ-011 SHALL have port init_flag  output  1  DUT init window indicator.
REQ-012 SHALL have port cycle  output  64  cycles elapsed since reset release.
REQ-013 SHALL have port state  output  3  encoding INIT=0, RUN=1, DRAIN=2, PASS=3, FAIL=4.
REQ-014 SHALL have port done  output  1  run finished (PASS or FAIL).
REQ-015 SHALL have port pass  output  1  run finished successfully.
REQ-016 SHALL have port fail_code  output  2  0 none, 1 watchdog timeout, 2 idle timeout after quit, 3 quit during INIT.

Function
REQ-017 All outputs SHALL be registered; each decision is visible on outputs the cycle after the deciding input is sampled.
REQ-018 cycle SHALL increment by 1 every cycle reset is high, saturating at 2^64-1.
REQ-019 INIT: 8-bit init counter increments each cycle; dut_reset=1 while counter<RESET_CYCLES; init_flag=1 while counter<INIT_CYCLES; transition to RUN when counter==RESET_CYCLES-1, so dut_reset is high for exactly RESET_CYCLES cycles after release.
REQ-020 On INIT->RUN, cfg_timeout and cfg_quit_timeout SHALL be latched; later changes have no effect until next reset.
REQ-021 quit_req in INIT SHALL go to FAIL, fail_code=3.
REQ-022 RUN: 32-bit watchdog counter clears to 0 on commit_valid, else increments, saturating at 2^32-1.
REQ-023 RUN: if latched cfg_timeout!=0 and watchdog counter==cfg_timeout with no commit_valid this cycle, go FAIL, fail_code=1.
REQ-024 RUN: quit_req with idle=1 goes PASS; quit_req with idle=0 goes DRAIN and clears the drain counter.
REQ-025 Priority in RUN: quit_req > commit_valid > watchdog timeout.
REQ-026 DRAIN: drain counter increments each cycle; idle=1 goes PASS; else drain counter==latched cfg_quit_timeout goes FAIL, fail_code=2; idle wins when simultaneous; cfg_quit_timeout=0 fails on first non-idle DRAIN cycle.
REQ-027 DRAIN: commit_valid and quit_req SHALL be ignored.
REQ-028 PASS: done=1, pass=1, fail_code=0; FAIL: done=1, pass=0; both terminal until reset; cycle keeps counting.
REQ-029 done, pass and fail_code SHALL be 0 in INIT, RUN and DRAIN.

Reset
REQ-030 reset low at a rising edge SHALL set state=INIT, init counter=0, watchdog and drain counters=0, cycle=0, dut_reset=1, init_flag=(INIT_CYCLES>0), done=0, pass=0, fail_code=0.
REQ-031 reset asserted mid-RUN, DRAIN, PASS or FAIL SHALL abort immediately to the REQ-030 state with no residual status.

Verification
REQ-032 Defaults, reset released at cycle 0 -> dut_reset high cycles 0-4, init_flag high cycle 0 only, state=RUN from cycle 5.
REQ-033 cfg_timeout=10, no commits after RUN entry -> FAIL, fail_code=1, done=1 within 12 cycles of RUN entry; commit every 5 cycles -> never fails.
REQ-034 quit_req with idle=1 in RUN -> next cycle state=PASS, pass=1, done=1.
REQ-035 cfg_quit_timeout=4, quit_req with idle=0, idle stays 0 -> FAIL fail_code=2 after 4 DRAIN cycles; repeat with idle rising on DRAIN cycle 4 -> PASS.
REQ-036 quit_req and watchdog expiry same cycle -> PASS/DRAIN, not FAIL; quit_req during INIT -> FAIL fail_code=3.
REQ-037 reset pulsed low one cycle while in FAIL -> state=INIT, done=0, fail_code=0, cycle restarts at 0.
